pattern_gen: RTL and testbench

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_pkg.sv | 15 +
 rtl/bounce_ctrl.sv | 83 ++++++++
 rtl/pattern_gen.sv | 172 +++++++++++++++++
 tb/tb_pattern_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared definitions for the test-pattern generator.
//   mode_e      : display modes selectable through the mode handshake
//   CHECK_SHIFT : checkerboard cell size exponent (cells of 2**CHECK_SHIFT px)
package pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BARS   = 2'd0,
    MODE_CHECK  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_GRID   = 2'd3
  } mode_e;

  localparam int CHECK_SHIFT = 5;

endpackage

// File: rtl/bounce_ctrl.sv
// Bouncing-square position tracker. The square moves one pixel per axis on
// every frame pulse and reverses direction on reaching a screen edge.
//   clk_pix  : pixel clock
//   rst_pix  : synchronous active-high reset (position 0,0, moving +x/+y)
//   frame_i  : one-cycle start-of-frame pulse
//   bx_o/by_o: top-left corner of the square
module bounce_ctrl #(
  parameter int CORDW = 10,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int SQ    = 32
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             frame_i,
  output logic [CORDW-1:0] bx_o,
  output logic [CORDW-1:0] by_o
);

  localparam logic [CORDW-1:0] X_MAX = CORDW'(H_RES - SQ);
  localparam logic [CORDW-1:0] Y_MAX = CORDW'(V_RES - SQ);

  logic [CORDW-1:0] bx_q, bx_d, by_q, by_d;
  logic             dxn_q, dxn_d, dyn_q, dyn_d;  // 1 = moving towards 0

  always_comb begin
    bx_d  = bx_q;
    by_d  = by_q;
    dxn_d = dxn_q;
    dyn_d = dyn_q;
    if (frame_i) begin
      // An edge hit reverses direction and steps away in the same frame.
      if (!dxn_q) begin
        if (bx_q == X_MAX) begin
          dxn_d = 1'b1;
          bx_d  = bx_q - 1'b1;
        end else begin
          bx_d  = bx_q + 1'b1;
        end
      end else begin
        if (bx_q == '0) begin
          dxn_d = 1'b0;
          bx_d  = bx_q + 1'b1;
        end else begin
          bx_d  = bx_q - 1'b1;
        end
      end
      if (!dyn_q) begin
        if (by_q == Y_MAX) begin
          dyn_d = 1'b1;
          by_d  = by_q - 1'b1;
        end else begin
          by_d  = by_q + 1'b1;
        end
      end else begin
        if (by_q == '0) begin
          dyn_d = 1'b0;
          by_d  = by_q + 1'b1;
        end else begin
          by_d  = by_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      bx_q  <= '0;
      by_q  <= '0;
      dxn_q <= 1'b0;
      dyn_q <= 1'b0;
    end else begin
      bx_q  <= bx_d;
      by_q  <= by_d;
      dxn_q <= dxn_d;
      dyn_q <= dyn_d;
    end
  end

  assign bx_o = bx_q;
  assign by_o = by_q;

endmodule

// File: rtl/pattern_gen.sv
// Video test-pattern generator with four frame-synchronous modes.
//   clk_pix, rst_pix           : pixel clock, synchronous active-high reset
//   sx, sy, de, frame          : raster position, active-video flag, frame pulse
//   mode_req/mode_vld/mode_rdy : mode change request handshake
//   mode_cur                   : mode currently displayed
//   rgb_r/g/b, rgb_de          : colour and aligned active flag (2-cycle latency)
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int CORDW = 10,
  parameter int CHANW = 8,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int SQ    = 32
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic             frame,
  input  logic [1:0]       mode_req,
  input  logic             mode_vld,
  output logic             mode_rdy,
  output logic [1:0]       mode_cur,
  output logic [CHANW-1:0] rgb_r,
  output logic [CHANW-1:0] rgb_g,
  output logic [CHANW-1:0] rgb_b,
  output logic             rgb_de
);

  localparam int               BAR_W = H_RES / 8;
  localparam int               GRID_MSB = 5;
  localparam logic [CHANW-1:0] FULL  = '1;
  localparam logic [CORDW:0]   SQ_E  = (CORDW+1)'(SQ);

  // Mode handshake and frame counter
  mode_e      mode_cur_q, mode_cur_d, pend_mode_q, pend_mode_d;
  logic       pend_vld_q, pend_vld_d;
  logic [7:0] fcnt_q, fcnt_d;

  assign mode_rdy = ~pend_vld_q;
  assign mode_cur = mode_cur_q;

  always_comb begin
    mode_cur_d  = mode_cur_q;
    pend_mode_d = pend_mode_q;
    pend_vld_d  = pend_vld_q;
    fcnt_d      = frame ? fcnt_q + 8'd1 : fcnt_q;
    // Only a request captured in an earlier cycle can be applied, so a
    // capture coinciding with a frame pulse waits for the next one.
    if (frame && pend_vld_q) begin
      mode_cur_d = pend_mode_q;
      pend_vld_d = 1'b0;
    end
    if (mode_vld && mode_rdy) begin
      pend_vld_d  = 1'b1;
      pend_mode_d = mode_e'(mode_req);
    end
  end

  logic [CORDW-1:0] bx, by;

  bounce_ctrl #(
    .CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES), .SQ(SQ)
  ) u_bounce (
    .clk_pix(clk_pix),
    .rst_pix(rst_pix),
    .frame_i(frame),
    .bx_o   (bx),
    .by_o   (by)
  );

  // Stage 0: register raster inputs
  logic [CORDW-1:0] sx_p0, sy_p0;
  logic             vld_p0;

  always_ff @(posedge clk_pix) begin
    sx_p0 <= sx;
    sy_p0 <= sy;
  end

  // Stage 1: colour generation
  logic [CHANW-1:0] r_c, g_c, b_c;
  logic [2:0]       bar_idx;
  logic             in_sq, grid_on;
  logic [CORDW:0]   sx_e, sy_e, bx_e, by_e;

  assign bar_idx = 3'(sx_p0 / CORDW'(BAR_W));
  assign sx_e    = {1'b0, sx_p0};
  assign sy_e    = {1'b0, sy_p0};
  assign bx_e    = {1'b0, bx};
  assign by_e    = {1'b0, by};
  assign in_sq   = (sx_e >= bx_e) && (sx_e < bx_e + SQ_E) &&
                   (sy_e >= by_e) && (sy_e < by_e + SQ_E);
  assign grid_on = (sx_p0[GRID_MSB:0] == '0) || (sy_p0[GRID_MSB:0] == '0) ||
                   (sx_p0 == CORDW'(H_RES - 1)) || (sy_p0 == CORDW'(V_RES - 1));

  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    if (vld_p0) begin
      case (mode_cur_q)
        MODE_BARS: begin
          r_c = bar_idx[2] ? FULL : '0;
          g_c = bar_idx[1] ? FULL : '0;
          b_c = bar_idx[0] ? FULL : '0;
        end
        MODE_CHECK: begin
          // Even parity is white so the origin cell starts white at fcnt 0.
          if (!(sx_p0[CHECK_SHIFT] ^ sy_p0[CHECK_SHIFT] ^ fcnt_q[CHECK_SHIFT])) begin
            r_c = FULL;
            g_c = FULL;
            b_c = FULL;
          end
        end
        MODE_BOUNCE: begin
          if (in_sq) begin
            r_c = FULL;
            g_c = FULL;
            b_c = FULL;
          end else begin
            r_c = sx_p0[CHANW-1:0];
            b_c = sy_p0[CHANW-1:0];
          end
        end
        MODE_GRID: begin
          if (grid_on) begin
            r_c = FULL;
            g_c = FULL;
            b_c = FULL;
          end
        end
      endcase
    end
  end

  // Stage 1 -> output registers
  logic [CHANW-1:0] r_p1, g_p1, b_p1;
  logic             vld_p1;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      mode_cur_q  <= MODE_BARS;
      pend_mode_q <= MODE_BARS;
      pend_vld_q  <= 1'b0;
      fcnt_q      <= '0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      r_p1        <= '0;
      g_p1        <= '0;
      b_p1        <= '0;
    end else begin
      mode_cur_q  <= mode_cur_d;
      pend_mode_q <= pend_mode_d;
      pend_vld_q  <= pend_vld_d;
      fcnt_q      <= fcnt_d;
      vld_p0      <= de;
      vld_p1      <= vld_p0;
      r_p1        <= r_c;
      g_p1        <= g_c;
      b_p1        <= b_c;
    end
  end

  assign rgb_r  = r_p1;
  assign rgb_g  = g_p1;
  assign rgb_b  = b_p1;
  assign rgb_de = vld_p1;

endmodule

// File: tb/tb_pattern_gen.sv
module tb_pattern_gen;

  localparam int CORDW = 10;
  localparam int CHANW = 8;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int SQ    = 32;

  logic             clk_pix = 1'b0;
  logic             rst_pix;
  logic [CORDW-1:0] sx, sy;
  logic             de, frame;
  logic [1:0]       mode_req;
  logic             mode_vld, mode_rdy;
  logic [1:0]       mode_cur;
  logic [CHANW-1:0] rgb_r, rgb_g, rgb_b;
  logic             rgb_de;

  always #5 clk_pix = ~clk_pix;

  pattern_gen #(
    .CORDW(CORDW), .CHANW(CHANW), .H_RES(H_RES), .V_RES(V_RES), .SQ(SQ)
  ) dut (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .sx      (sx),
    .sy      (sy),
    .de      (de),
    .frame   (frame),
    .mode_req(mode_req),
    .mode_vld(mode_vld),
    .mode_rdy(mode_rdy),
    .mode_cur(mode_cur),
    .rgb_r   (rgb_r),
    .rgb_g   (rgb_g),
    .rgb_b   (rgb_b),
    .rgb_de  (rgb_de)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state
  int m_mode, m_pmode, m_fcnt, m_bx, m_by, m_nfr;
  bit m_pend, m_dxn, m_dyn;

  int sb_q[$];

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_pmode = 0; m_pend = 0; m_fcnt = 0;
    m_bx = 0; m_by = 0; m_dxn = 0; m_dyn = 0; m_nfr = 0;
  endtask

  task automatic model_frame();
    m_nfr++;
    m_fcnt = (m_fcnt + 1) % 256;
    if (m_pend) begin
      m_mode = m_pmode;
      m_pend = 0;
    end
    if (!m_dxn) begin
      if (m_bx + SQ == H_RES) begin m_dxn = 1; m_bx = m_bx - 1; end
      else m_bx = m_bx + 1;
    end else begin
      if (m_bx == 0) begin m_dxn = 0; m_bx = 1; end
      else m_bx = m_bx - 1;
    end
    if (!m_dyn) begin
      if (m_by + SQ == V_RES) begin m_dyn = 1; m_by = m_by - 1; end
      else m_by = m_by + 1;
    end else begin
      if (m_by == 0) begin m_dyn = 0; m_by = 1; end
      else m_by = m_by - 1;
    end
  endtask

  function automatic int exp_pix(input int x, input int y, input bit d);
    int r, g, b, i;
    r = 0; g = 0; b = 0;
    if (!d) return 0;
    case (m_mode)
      0: begin
        i = x / (H_RES / 8);
        r = i[2] ? 255 : 0;
        g = i[1] ? 255 : 0;
        b = i[0] ? 255 : 0;
      end
      1: begin
        if ((((x / 32) + (y / 32) + (m_fcnt / 32)) % 2) == 0) begin
          r = 255; g = 255; b = 255;
        end
      end
      2: begin
        if (x >= m_bx && x < m_bx + SQ && y >= m_by && y < m_by + SQ) begin
          r = 255; g = 255; b = 255;
        end else begin
          r = x % 256;
          b = y % 256;
        end
      end
      default: begin
        if ((x % 64) == 0 || (y % 64) == 0 || x == H_RES - 1 || y == V_RES - 1) begin
          r = 255; g = 255; b = 255;
        end
      end
    endcase
    return (1 << 24) | (r << 16) | (g << 8) | b;
  endfunction

  // Drive one pixel, then compare the scoreboard entry two edges later.
  task automatic pix(input string tag, input int x, input int y, input bit d);
    int e;
    sx = CORDW'(x);
    sy = CORDW'(y);
    de = d;
    sb_q.push_back(exp_pix(x, y, d));
    tick();
    de = 1'b0;
    tick();
    e = sb_q.pop_front();
    chk(tag, int'({rgb_de, rgb_r, rgb_g, rgb_b}), e);
  endtask

  task automatic frame_pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    model_frame();
  endtask

  task automatic request(input int m);
    chk("rdy_idle", int'(mode_rdy), int'(!m_pend));
    mode_req = 2'(m);
    mode_vld = 1'b1;
    tick();
    mode_vld = 1'b0;
    m_pend = 1; m_pmode = m;
    chk("rdy_busy", int'(mode_rdy), 0);
  endtask

  task automatic to_fcnt(input int t);
    for (int k = 0; k < 300 && m_fcnt != t; k++) frame_pulse();
    chk("fcnt_reach", m_fcnt, t);
  endtask

  task automatic to_frame(input int n);
    for (int k = 0; k < 700 && m_nfr < n; k++) frame_pulse();
    chk("frame_reach", m_nfr, n);
  endtask

  initial begin
    rst_pix = 1'b1;
    sx = '0; sy = '0; de = 1'b0; frame = 1'b0;
    mode_req = '0; mode_vld = 1'b0;
    model_reset();
    tick(); tick(); tick();
    chk("rst_rgb", int'({rgb_r, rgb_g, rgb_b}), 0);
    chk("rst_de", int'(rgb_de), 0);
    chk("rst_mode", int'(mode_cur), 0);
    chk("rst_rdy", int'(mode_rdy), 1);
    rst_pix = 1'b0;

    // Colour bars
    pix("bar1", 80, 0, 1'b1);
    chk("bar1_blue", int'({rgb_de, rgb_r, rgb_g, rgb_b}), 32'h10000FF);
    pix("bar0", 0, 0, 1'b1);
    pix("bar5", 400, 5, 1'b1);
    pix("bar7", 639, 10, 1'b1);
    pix("blank", 300, 3, 1'b0);

    // Mid-frame mode request is held until the next frame pulse
    request(3);
    tick();
    chk("pend_mode", int'(mode_cur), 0);
    pix("pend_pix", 200, 7, 1'b1);
    chk("pend_rdy", int'(mode_rdy), 0);
    frame_pulse();
    chk("grid_mode", int'(mode_cur), 3);
    chk("grid_rdy", int'(mode_rdy), 1);
    pix("grid_x64", 64, 1, 1'b1);
    pix("grid_off", 65, 1, 1'b1);
    pix("grid_right", 639, 1, 1'b1);
    pix("grid_bot", 1, 479, 1'b1);
    pix("grid_in", 100, 100, 1'b1);

    // Capture in the same cycle as a frame pulse
    mode_req = 2'd1;
    mode_vld = 1'b1;
    frame = 1'b1;
    tick();
    mode_vld = 1'b0;
    frame = 1'b0;
    model_frame();
    m_pend = 1; m_pmode = 1;
    chk("coinc_mode", int'(mode_cur), m_mode);
    chk("coinc_rdy", int'(mode_rdy), 0);
    frame_pulse();
    chk("coinc_apply", int'(mode_cur), 1);
    chk("coinc_rdy1", int'(mode_rdy), 1);

    // Checkerboard across fcnt boundaries and wrap
    to_fcnt(31);
    pix("chk31_o", 0, 0, 1'b1);
    pix("chk31_n", 32, 0, 1'b1);
    to_fcnt(32);
    pix("chk32_o", 0, 0, 1'b1);
    to_fcnt(63);
    pix("chk63_o", 0, 0, 1'b1);
    to_fcnt(64);
    pix("chk64_o", 0, 0, 1'b1);
    to_fcnt(255);
    pix("chk255_o", 0, 0, 1'b1);
    to_fcnt(0);
    pix("chk0_o", 0, 0, 1'b1);
    pix("chk0_d", 32, 32, 1'b1);

    // Reset with a request pending
    request(2);
    rst_pix = 1'b1;
    de = 1'b1;
    sx = CORDW'(80);
    tick();
    model_reset();
    chk("rst2_mode", int'(mode_cur), 0);
    chk("rst2_rdy", int'(mode_rdy), 1);
    chk("rst2_rgb", int'({rgb_de, rgb_r, rgb_g, rgb_b}), 0);
    rst_pix = 1'b0;
    de = 1'b0;
    pix("resume", 80, 0, 1'b1);
    frame_pulse();
    chk("rst2_nopend", int'(mode_cur), 0);

    // Bouncing square
    request(2);
    frame_pulse();
    chk("bnc_mode", int'(mode_cur), 2);
    to_frame(448);
    pix("by448_in", 448, 448, 1'b1);
    pix("by448_above", 448, 447, 1'b1);
    pix("by448_right", 480, 448, 1'b1);
    to_frame(449);
    pix("by449_in", 449, 447, 1'b1);
    pix("by449_bot", 449, 479, 1'b1);
    to_frame(608);
    pix("bx608_in", 608, 288, 1'b1);
    pix("bx608_left", 607, 288, 1'b1);
    pix("bx608_edge", 639, 319, 1'b1);
    pix("bx608_below", 639, 320, 1'b1);
    to_frame(609);
    pix("bx609_in", 607, 287, 1'b1);
    pix("bx609_edge", 639, 287, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
